// File: rtl/uart_tx_port_pkg.sv
// uart_tx_port_pkg: register offsets, STATUS bit positions and serialiser states
package uart_tx_port_pkg;
  localparam int UART_TXDATA = 0;
  localparam int UART_STATUS = 4;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF = 3;
  localparam int ST_COUNT = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_port_byte_fifo.sv
// byte_fifo: power-of-2 byte FIFO with combinational head and occupancy count
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en, rd_en;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  // storage needs no reset: only slots behind valid pointers are ever read
  always_ff @(posedge clock)
    if (wr_en) mem_q[wr_q] <= din;
  // pointers wrap naturally at DEPTH; push+pop leaves the count unchanged
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter fed by a byte FIFO
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               CLK_RATE  = 6_250_000,
  parameter int               BAUD      = 115_200,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0006_1A80
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] wdata,
  input  logic             enw,
  output logic [WIDTH-1:0] rdata,
  output logic             sel,
  output logic             txd,
  output logic             busy
);
  localparam int DIV = CLK_RATE / BAUD;
  localparam int BW = $clog2(DIV);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] LAST = BW'(DIV - 1);
  localparam logic [WIDTH-1:0] TX_ADDR = BASE_ADDR + WIDTH'(UART_TXDATA);
  localparam logic [WIDTH-1:0] ST_ADDR = BASE_ADDR + WIDTH'(UART_STATUS);
  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, busy_q, ovf_q;
  logic          hit_tx, hit_st, push, pop, clr, full, empty, wrap;
  logic [7:0]    dout;
  logic [CW-1:0] count;
  logic          unused_bits;
  assign hit_tx = address[WIDTH-1:2] == TX_ADDR[WIDTH-1:2];
  assign hit_st = address[WIDTH-1:2] == ST_ADDR[WIDTH-1:2];
  assign sel    = hit_tx || hit_st;
  assign push   = enw && hit_tx;
  assign clr    = enw && hit_st && wdata[ST_OVF];
  assign wrap   = baud_q == LAST;
  assign txd    = txd_q;
  assign busy   = busy_q;
  assign unused_bits = ^{wdata[WIDTH-1:8], address[1:0]};
  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .nreset(nreset),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // STATUS readback; TXDATA and unmapped addresses read as zero
  always_comb begin
    rdata = '0;
    if (hit_st) begin
      rdata[ST_FULL]       = full;
      rdata[ST_EMPTY]      = empty;
      rdata[ST_ACTIVE]     = state_q != IDLE;
      rdata[ST_OVF]        = ovf_q;
      rdata[ST_COUNT +: 8] = 8'(count);
    end
  end
  // serialiser next state: every line bit is held for DIV cycles
  always_comb begin
    state_d = state_q;
    baud_d  = wrap ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = dout;
          state_d = START;
        end
      end
      START: if (wrap) begin
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (wrap) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // registered line output and busy lag the FSM by one cycle so they stay glitch-free and aligned
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
      busy_q  <= state_q != IDLE || !empty;
      ovf_q   <= (push && full && !pop) ? 1'b1 : clr ? 1'b0 : ovf_q;
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed checks of decode, FIFO, overflow, framing and reset
module tb_uart_tx_port;
  localparam logic [31:0] BASE = 32'h0006_1A80;
  localparam logic [31:0] STAT = BASE + 32'd4;
  logic        clock = 0, nreset = 0, enw = 0;
  logic [31:0] address = 0, wdata = 0, rdata;
  logic        sel, txd, busy;
  int          n_vec = 0, n_miss = 0, cyc = 0, lows, tt, t2 [3];
  logic [9:0]  fr;
  logic [7:0]  b;
  logic [7:0]  got3 [17];
  logic [7:0]  got4 [18];

  uart_tx_port #(
    .WIDTH(32), .CLK_RATE(8), .BAUD(1), .DEPTH(16), .BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .nreset(nreset), .address(address), .wdata(wdata),
    .enw(enw), .rdata(rdata), .sel(sel), .txd(txd), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    wdata = d;
    enw = 1;
    tick();
    enw = 0;
  endtask

  task automatic rd_stat(input string tag, input logic [31:0] exp);
    address = STAT;
    #1;
    chk(tag, rdata, exp);
    chk({tag, "_sel"}, 32'(sel), 1);
  endtask

  task automatic rx(output logic [7:0] d, output int t0);
    logic ok;
    d = '0;
    t0 = 0;
    for (int i = 0; i < 300 && txd !== 1'b0; i++) tick();
    ok = txd === 1'b0;
    chk("rx_start_found", 32'(ok), 1);
    if (ok) begin
      t0 = cyc;
      tick(4);
      chk("rx_start_mid", 32'(txd), 0);
      for (int j = 0; j < 8; j++) begin
        tick(8);
        d[j] = txd;
      end
      tick(8);
      chk("rx_stop_mid", 32'(txd), 1);
      tick(4);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    rd_stat("rst_status", 32'h2);
    nreset = 1;
    tick(2);

    wr(BASE, 32'hFFFF_FF55);
    rd_stat("t1_pending", 32'h0000_0100);
    tick();
    chk("t1_pre_txd", 32'(txd), 1);
    chk("t1_busy", 32'(busy), 1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 80; c++) begin
      tick();
      chk("t1_txd", 32'(txd), 32'(fr[c/8]));
    end
    chk("t1_busy_stop", 32'(busy), 1);
    tick();
    chk("t1_idle_txd", 32'(txd), 1);
    chk("t1_busy_fall", 32'(busy), 0);
    rd_stat("t1_status", 32'h2);

    wr(BASE, 32'h01);
    wr(BASE, 32'h02);
    wr(BASE, 32'h03);
    rd_stat("t2_count_peak", 32'h0000_0204);
    for (int i = 0; i < 3; i++) begin
      rx(b, t2[i]);
      chk("t2_byte", 32'(b), 32'(i + 1));
    end
    chk("t2_gap1", 32'(t2[1] - t2[0]), 81);
    chk("t2_gap2", 32'(t2[2] - t2[1]), 81);
    chk("t2_busy", 32'(busy), 0);
    rd_stat("t2_status", 32'h2);

    fork
      begin
        for (int i = 0; i < 17; i++) rx(got3[i], tt);
      end
      begin
        for (int i = 0; i < 17; i++) wr(BASE, 32'h10 + i);
        rd_stat("t3_full", 32'h0000_1005);
        wr(BASE, 32'h21);
        rd_stat("t3_overflow", 32'h0000_100D);
        wr(STAT, 32'h8);
        rd_stat("t3_ovf_clear", 32'h0000_1005);
      end
    join
    for (int i = 0; i < 17; i++) chk("t3_byte", 32'(got3[i]), 32'h10 + i);
    lows = 0;
    repeat (100) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    chk("t3_no_18th", 32'(lows), 0);
    rd_stat("t3_end", 32'h2);

    fork
      begin
        for (int i = 0; i < 18; i++) rx(got4[i], tt);
      end
      begin
        for (int i = 0; i < 17; i++) wr(BASE, 32'h30 + i);
        tick(65);
        rd_stat("t4_full_idle", 32'h0000_1001);
        wr(BASE, 32'hAA);
        rd_stat("t4_after_push", 32'h0000_1005);
      end
    join
    for (int i = 0; i < 17; i++) chk("t4_byte", 32'(got4[i]), 32'h30 + i);
    chk("t4_last_aa", 32'(got4[17]), 32'hAA);
    rd_stat("t4_end", 32'h2);

    wr(BASE, 32'hA5);
    wr(BASE, 32'h77);
    tick(35);
    chk("t5_bit3", 32'(txd), 0);
    nreset = 0;
    #1;
    chk("t5_rst_txd", 32'(txd), 1);
    chk("t5_rst_busy", 32'(busy), 0);
    rd_stat("t5_rst_status", 32'h2);
    tick(2);
    nreset = 1;
    lows = 0;
    repeat (200) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    chk("t5_quiet", 32'(lows), 0);
    rd_stat("t5_status", 32'h2);
    wr(BASE, 32'h3C);
    rx(b, tt);
    chk("t5_next_byte", 32'(b), 32'h3C);

    address = BASE + 32'd8;
    #1;
    chk("t6_b8_sel", 32'(sel), 0);
    chk("t6_b8_rdata", rdata, 0);
    address = 32'h0000_0100;
    #1;
    chk("t6_ram_sel", 32'(sel), 0);
    chk("t6_ram_rdata", rdata, 0);
    address = BASE;
    #1;
    chk("t6_tx_sel", 32'(sel), 1);
    chk("t6_tx_rdata", rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
